// File: rtl/card_pkg.sv
// Shared constants, state encoding and rank helpers for the card dealer.
package card_pkg;

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned RANK_MAX  = 10;
    localparam int unsigned SUIT_CNT  = 4;
    localparam int unsigned TEN_CNT   = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PICK,
        ST_DELIVER,
        ST_EMPTY
    } state_t;

    // Fold a 4-bit random nibble onto ranks 1..10.
    function automatic logic [3:0] first_rank(input logic [3:0] nib);
        return ((nib >= 4'd10) ? (nib - 4'd10) : nib) + 4'd1;
    endfunction

    function automatic logic [3:0] next_rank(input logic [3:0] rank);
        return (rank == 4'd10) ? 4'd1 : (rank + 4'd1);
    endfunction

    function automatic logic [4:0] full_count(input logic [3:0] rank);
        return (rank == 4'd10) ? 5'(TEN_CNT) : 5'(SUIT_CNT);
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/deal bus between the game controller and the card dealer.
interface card_dealer_if;

    logic       CARD_REQ;
    logic       SHUFFLE;
    logic       CARD_VLD;
    logic [3:0] CARD_VAL;
    logic [5:0] CARDS_LEFT;
    logic       DECK_EMPTY;
    logic       BUSY;

    modport master (
        output CARD_REQ, SHUFFLE,
        input  CARD_VLD, CARD_VAL, CARDS_LEFT, DECK_EMPTY, BUSY
    );

    modport slave (
        input  CARD_REQ, SHUFFLE,
        output CARD_VLD, CARD_VAL, CARDS_LEFT, DECK_EMPTY, BUSY
    );

endinterface

// File: rtl/card_dealer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); never reaches zero from the seed.
module lfsr16
    import card_pkg::*;
(
    input  logic        SYS_CLK,
    input  logic        GEN_RES_N,
    output logic [15:0] Q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[0] ^ r_q[2] ^ r_q[3] ^ r_q[5];
    assign Q    = r_q;

    always_ff @(posedge SYS_CLK) begin
        if (!GEN_RES_N) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {w_fb, r_q[15:1]};
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals ranks 1..10 from a 52-card deck held as per-rank counters, picking with an LFSR.
module card_dealer
    import card_pkg::*;
(
    input  logic          SYS_CLK,
    input  logic          GEN_RES_N,
    card_dealer_if.slave  bus
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr_hi;
    logic [4:0]  r_cnt [1:RANK_MAX];
    logic [5:0]  r_left;
    logic [3:0]  r_cand;
    logic [3:0]  r_last;
    logic        w_load;
    logic        w_advance;
    logic        w_deliver;

    lfsr16 u_lfsr (
        .SYS_CLK   (SYS_CLK),
        .GEN_RES_N (GEN_RES_N),
        .Q         (w_lfsr)
    );

    assign w_unused_lfsr_hi = ^w_lfsr[15:4];

    always_ff @(posedge SYS_CLK) begin
        if (!GEN_RES_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_deliver = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.CARD_REQ) begin
                    if (r_left != '0) begin
                        w_next = ST_PICK;
                        w_load = 1'b1;
                    end else begin
                        w_next = ST_EMPTY;
                    end
                end
            end
            ST_PICK: begin
                if (r_cnt[r_cand] != '0) begin
                    w_next = ST_DELIVER;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_DELIVER: begin
                w_next    = ST_IDLE;
                w_deliver = 1'b1;
            end
            ST_EMPTY: begin
                w_next = ST_EMPTY;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // A restock aborts whatever deal is in flight, including the strobe itself.
        if (bus.SHUFFLE) begin
            w_next    = ST_IDLE;
            w_load    = 1'b0;
            w_advance = 1'b0;
            w_deliver = 1'b0;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!GEN_RES_N) begin
            for (int unsigned r = 1; r <= RANK_MAX; r++) begin
                r_cnt[r] <= full_count(4'(r));
            end
            r_left <= 6'(DECK_SIZE);
            r_cand <= 4'd1;
            r_last <= '0;
        end else if (bus.SHUFFLE) begin
            for (int unsigned r = 1; r <= RANK_MAX; r++) begin
                r_cnt[r] <= full_count(4'(r));
            end
            r_left <= 6'(DECK_SIZE);
        end else begin
            if (w_load) begin
                r_cand <= first_rank(w_lfsr[3:0]);
            end
            if (w_advance) begin
                r_cand <= next_rank(r_cand);
            end
            if (w_deliver) begin
                r_cnt[r_cand] <= r_cnt[r_cand] - 5'd1;
                r_left        <= r_left - 6'd1;
                r_last        <= r_cand;
            end
        end
    end

    assign bus.CARD_VLD   = w_deliver & GEN_RES_N;
    assign bus.CARD_VAL   = bus.CARD_VLD ? r_cand : r_last;
    assign bus.CARDS_LEFT = r_left;
    assign bus.DECK_EMPTY = (r_state == ST_EMPTY);
    assign bus.BUSY       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer checked every cycle against a deck-level reference model.
module tb_card_dealer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic req   = 1'b0;
    logic shf   = 1'b0;

    card_dealer_if bus ();

    assign bus.CARD_REQ = req;
    assign bus.SHUFFLE  = shf;

    card_dealer dut (
        .SYS_CLK   (clk),
        .GEN_RES_N (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    bit          chk_en = 1'b0;

    // Reference model: deck contents plus a scheduled strobe for the deal in flight.
    int          m_cnt [1:10];
    int          m_left;
    int          m_rank;
    int          m_last;
    int          m_strobe;
    int          cyc = 0;
    bit          m_pend;
    bit          m_empty;
    logic [15:0] m_lfsr;

    int          hist [0:15];
    int          n_strobe;
    int          got;
    int          lat;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic restock();
        for (int r = 1; r <= 9; r++) m_cnt[r] = 4;
        m_cnt[10] = 16;
        m_left    = 52;
    endtask

    task automatic compare_all();
        bit exp_vld;
        int exp_val;
        if (!chk_en) return;
        exp_vld = m_pend && (cyc == m_strobe) && !shf && rst_n;
        exp_val = exp_vld ? m_rank : m_last;
        chk("card_vld",   int'(bus.CARD_VLD),   int'(exp_vld));
        chk("card_val",   int'(bus.CARD_VAL),   exp_val);
        chk("cards_left", int'(bus.CARDS_LEFT), m_left);
        chk("busy",       int'(bus.BUSY),       int'(m_pend || m_empty));
        chk("deck_empty", int'(bus.DECK_EMPTY), int'(m_empty));
    endtask

    task automatic model_edge();
        bit strobe;
        int c;
        int k;
        if (!rst_n) begin
            restock();
            m_lfsr  = 16'hACE1;
            m_pend  = 1'b0;
            m_empty = 1'b0;
            m_last  = 0;
        end else begin
            strobe = m_pend && (cyc == m_strobe);
            if (shf) begin
                restock();
                m_pend  = 1'b0;
                m_empty = 1'b0;
            end else if (strobe) begin
                m_cnt[m_rank]--;
                m_left--;
                m_last = m_rank;
                m_pend = 1'b0;
            end else if (!m_pend && !m_empty && req) begin
                if (m_left == 0) begin
                    m_empty = 1'b1;
                end else begin
                    c = (int'(m_lfsr[3:0]) % 10) + 1;
                    k = 0;
                    while (m_cnt[c] == 0 && k < 10) begin
                        c = (c % 10) + 1;
                        k++;
                    end
                    m_rank   = c;
                    m_strobe = cyc + 2 + k;
                    m_pend   = 1'b1;
                end
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        advance();
        advance();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            sample();
            chk("rst_left",  int'(bus.CARDS_LEFT), 52);
            chk("rst_val",   int'(bus.CARD_VAL),   0);
            chk("rst_vld",   int'(bus.CARD_VLD),   0);
            chk("rst_busy",  int'(bus.BUSY),       0);
            chk("rst_empty", int'(bus.DECK_EMPTY), 0);
            advance();
        end

        // LFSR five steps past 16'hACE1 is 16'h1567: low nibble 7 -> rank 8.
        req = 1'b1;
        step();
        req = 1'b0;
        sample();
        chk("first_busy_n1", int'(bus.BUSY), 1);
        advance();
        sample();
        chk("first_vld_n2", int'(bus.CARD_VLD), 1);
        chk("first_val_n2", int'(bus.CARD_VAL), 8);
        advance();
        sample();
        chk("first_left_n3", int'(bus.CARDS_LEFT), 51);
        chk("first_val_hold", int'(bus.CARD_VAL), 8);
        advance();

        shf = 1'b1;
        step();
        shf = 1'b0;
        sample();
        chk("shuffle_left", int'(bus.CARDS_LEFT), 52);
        advance();

        for (int r = 0; r < 16; r++) hist[r] = 0;
        n_strobe = 0;
        for (int d = 0; d < 52; d++) begin
            req = 1'b1;
            step();
            got = 0;
            lat = 0;
            for (int w = 1; w <= 13; w++) begin
                req = (w <= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                sample();
                if (bus.CARD_VLD) begin
                    n_strobe++;
                    hist[bus.CARD_VAL]++;
                    if (got == 0) lat = w;
                    got++;
                end
                advance();
            end
            req = 1'b0;
            chk("deal_one_strobe", got, 1);
            chk("deal_latency_in_range", int'(lat >= 2 && lat <= 11), 1);
        end
        chk("deck_strobes", n_strobe, 52);
        for (int r = 1; r <= 10; r++) chk("deck_rank_hist", hist[r], (r == 10) ? 16 : 4);
        chk("deck_left_zero", int'(bus.CARDS_LEFT), 0);
        chk("deck_not_empty_yet", int'(bus.DECK_EMPTY), 0);

        req = 1'b1;
        step();
        req = 1'b0;
        sample();
        chk("req53_empty", int'(bus.DECK_EMPTY), 1);
        advance();
        got = 0;
        for (int w = 0; w < 12; w++) begin
            req = 1'($urandom_range(0, 1));
            sample();
            if (bus.CARD_VLD) got++;
            advance();
        end
        req = 1'b0;
        chk("req53_no_strobe", got, 0);
        chk("empty_sticky", int'(bus.DECK_EMPTY), 1);

        shf = 1'b1;
        step();
        shf = 1'b0;
        sample();
        chk("empty_exit_flag", int'(bus.DECK_EMPTY), 0);
        chk("empty_exit_left", int'(bus.CARDS_LEFT), 52);
        advance();

        req = 1'b1;
        step();
        req = 1'b0;
        step();
        shf = 1'b1;
        sample();
        chk("shuffle_deliver_vld", int'(bus.CARD_VLD), 0);
        advance();
        shf = 1'b0;
        sample();
        chk("shuffle_deliver_left", int'(bus.CARDS_LEFT), 52);
        chk("shuffle_deliver_busy", int'(bus.BUSY), 0);
        advance();

        shf = 1'b1;
        req = 1'b1;
        step();
        shf = 1'b0;
        req = 1'b0;
        sample();
        chk("shuffle_req_busy", int'(bus.BUSY), 0);
        advance();
        got = 0;
        for (int w = 0; w < 12; w++) begin
            sample();
            if (bus.CARD_VLD) got++;
            advance();
        end
        chk("shuffle_req_no_deal", got, 0);

        for (int d = 0; d < 22; d++) begin
            req = 1'b1;
            step();
            req = 1'b0;
            repeat (13) step();
        end
        chk("pre_reset_left", int'(bus.CARDS_LEFT), 30);
        req = 1'b1;
        step();
        req   = 1'b0;
        rst_n = 1'b0;
        sample();
        chk("reset_pick_busy", int'(bus.BUSY), 1);
        advance();
        rst_n = 1'b1;
        sample();
        chk("reset_pick_left", int'(bus.CARDS_LEFT), 52);
        chk("reset_pick_idle", int'(bus.BUSY), 0);
        advance();
        got = 0;
        for (int w = 0; w < 12; w++) begin
            sample();
            if (bus.CARD_VLD) got++;
            advance();
        end
        chk("reset_pick_no_strobe", got, 0);

        for (int i = 0; i < 600; i++) begin
            req   = 1'($urandom_range(0, 3) == 0);
            shf   = 1'($urandom_range(0, 49) == 0);
            rst_n = 1'($urandom_range(0, 299) != 0);
            step();
        end
        req   = 1'b0;
        shf   = 1'b0;
        rst_n = 1'b1;
        repeat (15) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have ports: SYS_CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: GEN_RES_N  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: CARD_REQ  in  1  request one card, single-cycle pulse from the game controller.
REQ-004 SHALL have ports: SHUFFLE  in  1  restock the full 52-card deck, active-high, sampled every cycle.
REQ-005 SHALL have ports: CARD_VLD  out  1  one-cycle strobe, CARD_VAL valid.
REQ-006 SHALL have ports: CARD_VAL  out  4  dealt rank, 1..10 (1 = ace, 10 = ten/J/Q/K).
REQ-007 SHALL have ports: CARDS_LEFT  out  6  cards remaining, 0..52.
REQ-008 SHALL have ports: DECK_EMPTY  out  1  high while in EMPTY state.
REQ-009 SHALL have ports: BUSY  out  1  high in any state other than IDLE.
REQ-010 SHALL use one clock (SYS_CLK) and a synchronous, active-low reset (GEN_RES_N); no other clock is used.

Function
REQ-011 SHALL hold ten rank counters: ranks 1..9 hold 0..4, rank 10 holds 0..16; full deck = 4 x 9 + 16 = 52.
REQ-012 SHALL run a 16-bit Fibonacci LFSR every cycle, taps 16,14,13,11, seed 16'hACE1; the LFSR never reaches zero.
REQ-013 SHALL implement states IDLE, PICK, DELIVER, EMPTY.
REQ-014 IDLE: on CARD_REQ=1 with CARDS_LEFT>0, go to PICK and load candidate rank = (LFSR[3:0] >= 10 ? LFSR[3:0]-10 : LFSR[3:0]) + 1.
REQ-015 IDLE: on CARD_REQ=1 with CARDS_LEFT=0, go to EMPTY; no CARD_VLD.
REQ-016 PICK: if counter[candidate]>0, go to DELIVER; else advance candidate by 1 per cycle (10 wraps to 1) and stay in PICK.
REQ-017 DELIVER: drive CARD_VLD=1 and CARD_VAL=candidate for exactly one cycle; decrement counter[candidate] and CARDS_LEFT by 1; go to IDLE.
REQ-018 Latency from CARD_REQ to CARD_VLD SHALL be 2 cycles when the first candidate is available and at most 11 cycles otherwise.
REQ-019 CARD_REQ outside IDLE SHALL be ignored; requests are not queued.
REQ-020 EMPTY: DECK_EMPTY=1; CARD_REQ ignored; exit only via SHUFFLE or reset.
REQ-021 SHUFFLE=1 in any state SHALL, on the next edge, restock all counters, set CARDS_LEFT=52, and enter IDLE.
REQ-022 A SHUFFLE during PICK or DELIVER SHALL abort the deal; no CARD_VLD is issued and no counter is decremented.
REQ-023 SHUFFLE and CARD_REQ in the same cycle: SHUFFLE wins and the request is dropped.
REQ-024 The LFSR SHALL NOT be affected by SHUFFLE.
REQ-025 CARD_VAL SHALL hold its last dealt value when CARD_VLD=0; it SHALL be 0 after reset.
REQ-026 Counters SHALL never underflow; CARDS_LEFT SHALL always equal the sum of the ten rank counters.

Reset
REQ-027 GEN_RES_N=0 at a rising edge SHALL set: state IDLE, LFSR=16'hACE1, full deck, CARDS_LEFT=52, CARD_VLD=0, CARD_VAL=0, DECK_EMPTY=0, BUSY=0.
REQ-028 Reset asserted mid-deal SHALL abort the deal; no CARD_VLD is issued on or after the reset edge.
REQ-029 Reset SHALL take priority over SHUFFLE and CARD_REQ.

Structure
REQ-030 Package card_pkg SHALL hold DECK_SIZE=52, RANK_MAX=10, SUIT_CNT=4, TEN_CNT=16, LFSR_SEED=16'hACE1, and the state encoding.
REQ-031 The LFSR SHALL be a sub-module, lfsr16 (ports SYS_CLK, GEN_RES_N, Q[15:0]).
REQ-032 card_dealer SHALL feed the CARD_VAL/CARD_VLD pair directly to V_BJACK's card input; there is no glue logic between them.

Verification
REQ-033 Reset, then idle for 5 cycles: CARDS_LEFT=52, CARD_VAL=0, CARD_VLD=0, BUSY=0, DECK_EMPTY=0.
REQ-034 Full deck, one CARD_REQ pulse at cycle N: BUSY=1 at N+1, CARD_VLD=1 at exactly N+2, CARDS_LEFT=51 at N+3.
REQ-035 Issue 52 spaced requests: exactly 52 strobes, ranks 1..9 four times each, rank 10 sixteen times, CARDS_LEFT=0; the 53rd request gives DECK_EMPTY=1 and no strobe.
REQ-036 Drain ranks 1..9 via forced LFSR values, then request: candidate walks up to rank 10 and latency is at most 11 cycles.
REQ-037 SHUFFLE in the DELIVER cycle: no CARD_VLD, CARDS_LEFT=52 next cycle. SHUFFLE together with CARD_REQ: no deal, state IDLE.
REQ-038 GEN_RES_N=0 during PICK with CARDS_LEFT=30: next cycle CARDS_LEFT=52, BUSY=0, and no strobe ever appears for that request.
